front_panel_seq: RTL and testbench
==================================

Name: front_panel_seq

Overview:
Single sequencer for the Altair front-panel functions: EXAMINE, EXAMINE NEXT, DEPOSIT, DEPOSIT NEXT and RESET. It jams opcode bytes onto the i8080 data-in bus and gates the CPU clock enable while paused. It also issues panel memory writes at the CPU's current address. It sits between the debounced panel pushbuttons and the top-level idata/write-port muxes.

Parameters:
TIMEOUT, 255, max clk cycles a command may stay busy before abort (8-bit counter).
RESET_VEC, 16'h0000, jump target used by RESET.

Ports:
clk  in  1  system clock
reset  in  1  async active-high reset
pause  in  1  panel run/stop switch; 1 = stopped, commands accepted
cmd_reset  in  1  one-cycle pulse, debounced RESET button
cmd_exam  in  1  one-cycle pulse, EXAMINE
cmd_exam_next  in  1  one-cycle pulse, EXAMINE NEXT
cmd_dep  in  1  one-cycle pulse, DEPOSIT
cmd_dep_next  in  1  one-cycle pulse, DEPOSIT NEXT
sw_lo  in  8  data/low-address switches
sw_hi  in  8  high-address switches
cpu_ce_slot  in  1  free-running half-rate enable slot (ce2)
cpu_rd  in  1  CPU read strobe
cpu_fetch  in  1  CPU starting opcode fetch (sync & status M1)
jam_en  out  1  select jam_data onto CPU idata
jam_data  out  8  byte to jam
step_ce  out  1  CPU clock-enable request, OR'd into CPU ce
dep_we  out  1  one-cycle panel memory write at current CPU address
dep_data  out  8  write data
busy  out  1  command in progress
err  out  1  sticky timeout flag; cleared by next accepted command

Behaviour:
- Reset (async): state IDLE; all outputs 0; byte index 0; timeout counter 0; captured switches 0.
- Acceptance:
  - Only in IDLE with pause=1. Command pulses outside IDLE, or with pause=0, are ignored.
  - Priority when several pulse together: cmd_reset > cmd_exam > cmd_exam_next > cmd_dep > cmd_dep_next.
  - On acceptance: sw_lo and sw_hi are captured, err is cleared, and busy=1 from the next cycle.
- Jam sequences:
  - RESET: C3, RESET_VEC[7:0], RESET_VEC[15:8].
  - EXAMINE: C3, sw_lo, sw_hi.
  - EXAMINE NEXT: 00.
  - DEPOSIT NEXT: 00, then write.
  - DEPOSIT: write only.
- States: IDLE -> JAM -> FETCH_WAIT -> (WRITE) -> IDLE. DEPOSIT goes IDLE -> WRITE directly.
- JAM state:
  - jam_en=1, jam_data = sequence[idx], step_ce = cpu_ce_slot.
  - idx advances on cpu_rd & cpu_ce_slot.
  - On consumption of the last byte, go to FETCH_WAIT. jam_en drops the following cycle.
- FETCH_WAIT state:
  - jam_en=0, step_ce = cpu_ce_slot.
  - On cpu_fetch & cpu_ce_slot, step_ce is forced 0 from the next cycle. The CPU then halts with the new PC on the address bus.
  - Next state is WRITE for DEPOSIT NEXT, IDLE otherwise.
- WRITE state: dep_we=1 for exactly one cycle, dep_data = captured sw_lo, then IDLE. step_ce=0 throughout.
- busy is high in every non-IDLE state. dep_data holds its last value in IDLE.
- Timeout:
  - Counter clears on acceptance and increments every cycle while busy.
  - Reaching TIMEOUT: err=1, all strobes 0, return to IDLE.
- pause falling to 0 mid-command: abort to IDLE the next cycle, no write, err unchanged. step_ce=0 (run-mode ce is owned by top level).
- Async reset mid-command: immediate IDLE, no dep_we pulse.
- step_ce is never asserted in IDLE.

Decomposition:
- altair_pkg:
  - opcode constants OP_JMP=8'hC3, OP_NOP=8'h00;
  - state enum {IDLE, JAM, FETCH_WAIT, WRITE};
  - command enum {C_RESET, C_EXAM, C_EXAM_NEXT, C_DEP, C_DEP_NEXT};
  - jam length per command.
- No sub-module is required; the sequence table is a combinational function in the package.

Test Plan:
- pause=1, sw_hi=12, sw_lo=34, cmd_exam pulse; CPU model reads 3 bytes -> jam_data C3,34,12 on successive cpu_rd, then step_ce stops the cycle after cpu_fetch with addr=1234, busy falls.
- After the above, cmd_exam_next -> single 00 jammed, CPU halts at fetch of 1235, no dep_we.
- CPU at 0100, sw_lo=A5, cmd_dep -> dep_we exactly one cycle with dep_data=A5, step_ce never asserted, busy 1 cycle.
- CPU at 0100, sw_lo=5A, cmd_dep_next -> 00 jammed, halt at 0101, then one dep_we with 5A while addr=0101.
- cmd_reset and cmd_dep on the same cycle -> RESET wins: C3,00,00 jammed, no write. A second pulse while busy is ignored.
- Model never asserts cpu_rd: err=1 after 255 busy cycles, IDLE. pause=0 mid-JAM -> IDLE next cycle, jam_en=0. Async reset mid-WRITE -> dep_we=0 immediately.

Source files
------------

// File: rtl/front_panel_seq_pkg.sv
// Shared opcodes, state/command encodings and jam tables for the Altair front-panel sequencer.
package front_panel_seq_pkg;

   localparam logic [7:0] OP_JMP = 8'hC3;
   localparam logic [7:0] OP_NOP = 8'h00;

   typedef enum logic [1:0] {IDLE, JAM, FETCH_WAIT, WRITE} state_t;

   typedef enum logic [2:0] {C_RESET, C_EXAM, C_EXAM_NEXT, C_DEP, C_DEP_NEXT} cmd_t;

   function automatic logic [1:0] jam_len(input cmd_t c);
      case (c)
         C_RESET, C_EXAM:         return 2'd3;
         C_EXAM_NEXT, C_DEP_NEXT: return 2'd1;
         default:                 return 2'd0;
      endcase
   endfunction

   // JMP-based commands jam a three-byte jump; the *_NEXT commands jam a single NOP.
   function automatic logic [7:0] jam_byte(input cmd_t c, input logic [1:0] idx,
                                           input logic [7:0] lo, input logic [7:0] hi,
                                           input logic [15:0] vec);
      logic [7:0] b;
      b = OP_NOP;
      if (c == C_RESET || c == C_EXAM) begin
         case (idx)
            2'd0:    b = OP_JMP;
            2'd1:    b = (c == C_RESET) ? vec[7:0]  : lo;
            default: b = (c == C_RESET) ? vec[15:8] : hi;
         endcase
      end
      return b;
   endfunction

endpackage

// File: rtl/front_panel_seq_if.sv
// Panel/CPU-side signal bundle of the front-panel sequencer; master drives the panel and CPU status.
interface front_panel_seq_if;
   logic       pause;
   logic       cmd_reset;
   logic       cmd_exam;
   logic       cmd_exam_next;
   logic       cmd_dep;
   logic       cmd_dep_next;
   logic [7:0] sw_lo;
   logic [7:0] sw_hi;
   logic       cpu_ce_slot;
   logic       cpu_rd;
   logic       cpu_fetch;
   logic       jam_en;
   logic [7:0] jam_data;
   logic       step_ce;
   logic       dep_we;
   logic [7:0] dep_data;
   logic       busy;
   logic       err;

   modport master (
      output pause, cmd_reset, cmd_exam, cmd_exam_next, cmd_dep, cmd_dep_next,
             sw_lo, sw_hi, cpu_ce_slot, cpu_rd, cpu_fetch,
      input  jam_en, jam_data, step_ce, dep_we, dep_data, busy, err
   );

   modport slave (
      input  pause, cmd_reset, cmd_exam, cmd_exam_next, cmd_dep, cmd_dep_next,
             sw_lo, sw_hi, cpu_ce_slot, cpu_rd, cpu_fetch,
      output jam_en, jam_data, step_ce, dep_we, dep_data, busy, err
   );
endinterface

// File: rtl/front_panel_seq.sv
// Front-panel command sequencer: jams opcodes, single-steps the CPU to the next fetch and issues panel writes.
// Commands accepted only when idle and paused; busy from the cycle after acceptance, aborted on timeout or run.
module front_panel_seq
   import front_panel_seq_pkg::*;
#(
   parameter logic [7:0]  TIMEOUT   = 8'd255,
   parameter logic [15:0] RESET_VEC = 16'h0000
) (
   input  logic             clk,
   input  logic             reset,
   front_panel_seq_if.slave fp
);

   state_t     state;
   cmd_t       cmd_q;
   logic [1:0] idx;
   logic [7:0] tmo_cnt;
   logic [7:0] sw_lo_q;
   logic [7:0] sw_hi_q;
   logic       jam_en_q;
   logic       dep_we_q;
   logic [7:0] dep_data_q;
   logic       busy_q;
   logic       err_q;

   logic       cmd_any;
   cmd_t       cmd_sel;
   logic       rd_slot;
   logic       fetch_slot;
   logic       tmo_hit;

   always_comb begin
      cmd_any = 1'b1;
      cmd_sel = C_RESET;
      if (fp.cmd_reset)          cmd_sel = C_RESET;
      else if (fp.cmd_exam)      cmd_sel = C_EXAM;
      else if (fp.cmd_exam_next) cmd_sel = C_EXAM_NEXT;
      else if (fp.cmd_dep)       cmd_sel = C_DEP;
      else if (fp.cmd_dep_next)  cmd_sel = C_DEP_NEXT;
      else                       cmd_any = 1'b0;
   end

   assign rd_slot    = fp.cpu_rd & fp.cpu_ce_slot;
   assign fetch_slot = fp.cpu_fetch & fp.cpu_ce_slot;
   assign tmo_hit    = (tmo_cnt == TIMEOUT - 8'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cmd_q      <= C_RESET;
         idx        <= 2'd0;
         tmo_cnt    <= 8'd0;
         sw_lo_q    <= 8'd0;
         sw_hi_q    <= 8'd0;
         jam_en_q   <= 1'b0;
         dep_we_q   <= 1'b0;
         dep_data_q <= 8'd0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         dep_we_q <= 1'b0;
         case (state)
            IDLE: begin
               if (fp.pause && cmd_any) begin
                  cmd_q   <= cmd_sel;
                  sw_lo_q <= fp.sw_lo;
                  sw_hi_q <= fp.sw_hi;
                  err_q   <= 1'b0;
                  tmo_cnt <= 8'd0;
                  idx     <= 2'd0;
                  busy_q  <= 1'b1;
                  if (cmd_sel == C_DEP) begin
                     state      <= WRITE;
                     dep_we_q   <= 1'b1;
                     dep_data_q <= fp.sw_lo;
                  end else begin
                     state    <= JAM;
                     jam_en_q <= 1'b1;
                  end
               end
            end
            default: begin
               tmo_cnt <= tmo_cnt + 8'd1;
               // Timeout and a return to run mode both abandon the command without writing.
               if (tmo_hit || !fp.pause) begin
                  state    <= IDLE;
                  busy_q   <= 1'b0;
                  jam_en_q <= 1'b0;
                  if (tmo_hit) err_q <= 1'b1;
               end else begin
                  case (state)
                     JAM: begin
                        if (rd_slot) begin
                           if (idx == jam_len(cmd_q) - 2'd1) begin
                              state    <= FETCH_WAIT;
                              jam_en_q <= 1'b0;
                           end else begin
                              idx <= idx + 2'd1;
                           end
                        end
                     end
                     FETCH_WAIT: begin
                        if (fetch_slot) begin
                           if (cmd_q == C_DEP_NEXT) begin
                              state      <= WRITE;
                              dep_we_q   <= 1'b1;
                              dep_data_q <= sw_lo_q;
                           end else begin
                              state  <= IDLE;
                              busy_q <= 1'b0;
                           end
                        end
                     end
                     default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   // Clock enable follows the free-running slot only while stepping; run-mode enable lives at top level.
   assign fp.step_ce  = (state == JAM || state == FETCH_WAIT) && fp.pause && fp.cpu_ce_slot;
   assign fp.jam_en   = jam_en_q;
   assign fp.jam_data = jam_en_q ? jam_byte(cmd_q, idx, sw_lo_q, sw_hi_q, RESET_VEC) : 8'h00;
   assign fp.dep_we   = dep_we_q;
   assign fp.dep_data = dep_data_q;
   assign fp.busy     = busy_q;
   assign fp.err      = err_q;

endmodule

// File: tb/tb_front_panel_seq.sv
// Bench for front_panel_seq: a small i8080 bus model consumes jammed bytes; results are checked against
// per-command expectations (jam list, final PC, write address/data) derived from the command rules.
module tb_front_panel_seq;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   front_panel_seq_if bus ();
   front_panel_seq dut (.clk(clk), .reset(reset), .fp(bus.slave));

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ph;
   logic [15:0] pc, pc0;
   logic [7:0]  lo_b;
   logic        mute;
   logic        s_ce, s_rd, s_jen, s_we, s_busy, s_err;
   logic [7:0]  s_jd, s_dd;
   int          busy_cycles, ce_cycles, idle_ce, wr_cnt;
   logic [7:0]  wr_data;
   logic [15:0] wr_addr;
   logic [7:0]  seen[$];
   logic [15:0] rv = 16'h0000;
   bit          done;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmds(input logic [4:0] m);
      bus.cmd_reset     = m[0];
      bus.cmd_exam      = m[1];
      bus.cmd_exam_next = m[2];
      bus.cmd_dep       = m[3];
      bus.cmd_dep_next  = m[4];
   endtask

   // Bus model: phase 0 = opcode fetch start, 1 = opcode read, 2/3 = operand reads.
   task automatic drive_cpu();
      bus.cpu_fetch = (ph == 0);
      bus.cpu_rd    = !mute && (ph != 0);
   endtask

   task automatic step();
      logic [7:0] b;
      #1;
      s_ce = bus.step_ce;  s_rd = bus.cpu_rd;  s_jen = bus.jam_en;  s_jd = bus.jam_data;
      s_we = bus.dep_we;   s_dd = bus.dep_data; s_busy = bus.busy;  s_err = bus.err;
      if (s_busy) busy_cycles++;
      if (s_ce) ce_cycles++;
      if (s_ce && !s_busy) idle_ce++;
      if (s_we) begin wr_cnt++; wr_data = s_dd; wr_addr = pc; end
      @(posedge clk);
      if (s_ce) begin
         b = s_jen ? s_jd : 8'hEE;
         case (ph)
            0: ph = 1;
            1: if (s_rd) begin seen.push_back(b); pc = pc + 16'd1; ph = (b == 8'hC3) ? 2 : 0; end
            2: if (s_rd) begin seen.push_back(b); lo_b = b; ph = 3; end
            default: if (s_rd) begin seen.push_back(b); pc = {b, lo_b}; ph = 0; end
         endcase
      end
      @(negedge clk);
      bus.cpu_ce_slot = ~bus.cpu_ce_slot;
      set_cmds(5'b0);
      drive_cpu();
   endtask

   task automatic issue(input logic [4:0] m, input int extra_at, input logic [4:0] xm);
      busy_cycles = 0; ce_cycles = 0; idle_ce = 0; wr_cnt = 0; seen.delete(); pc0 = pc;
      set_cmds(m);
      step();
      done = 0;
      for (int n = 0; n < 400 && !done; n++) begin
         if (n == extra_at) set_cmds(xm);
         step();
         if (!s_busy) done = 1;
      end
      chk("cmd_completes", done, 1);
   endtask

   task automatic check_cmd(input logic [4:0] m, input logic [7:0] lo, input logic [7:0] hi);
      int          w;
      logic [7:0]  exp_q[$];
      logic [15:0] exp_pc, exp_wa;
      int          exp_wr;
      w = -1;
      for (int i = 4; i >= 0; i--) if (m[i]) w = i;
      exp_pc = pc0; exp_wa = pc0; exp_wr = 0;
      case (w)
         0: begin exp_q = '{8'hC3, rv[7:0], rv[15:8]}; exp_pc = rv; end
         1: begin exp_q = '{8'hC3, lo, hi}; exp_pc = {hi, lo}; end
         2: begin exp_q = '{8'h00}; exp_pc = pc0 + 16'd1; end
         3: begin exp_wr = 1; end
         default: begin exp_q = '{8'h00}; exp_pc = pc0 + 16'd1; exp_wa = pc0 + 16'd1; exp_wr = 1; end
      endcase
      chk("jam_count", seen.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < seen.size()) chk("jam_byte", seen[i], exp_q[i]);
      chk("halt_pc", pc, exp_pc);
      chk("halt_at_fetch", ph, 1);
      chk("write_count", wr_cnt, exp_wr);
      if (exp_wr == 1 && wr_cnt == 1) begin
         chk("write_data", wr_data, lo);
         chk("write_addr", wr_addr, exp_wa);
      end
      chk("no_idle_step_ce", idle_ce, 0);
      chk("err_clear", s_err, 0);
      if (w == 3) begin
         chk("dep_busy_cycles", busy_cycles, 1);
         chk("dep_no_step_ce", ce_cycles, 0);
      end
   endtask

   task automatic run(input logic [4:0] m, input logic [7:0] lo, input logic [7:0] hi,
                      input int extra_at, input logic [4:0] xm);
      bus.sw_lo = lo; bus.sw_hi = hi;
      issue(m, extra_at, xm);
      check_cmd(m, lo, hi);
   endtask

   initial begin
      logic [4:0] m;
      reset = 1'b1; bus.pause = 1'b1; set_cmds(5'b0); bus.sw_lo = 8'h00; bus.sw_hi = 8'h00;
      bus.cpu_ce_slot = 1'b0; mute = 1'b0; ph = 1; pc = 16'h0000; lo_b = 8'h00; drive_cpu();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_jam_en", bus.jam_en, 0);   chk("rst_jam_data", bus.jam_data, 0);
      chk("rst_step_ce", bus.step_ce, 0); chk("rst_dep_we", bus.dep_we, 0);
      chk("rst_dep_data", bus.dep_data, 0); chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      @(negedge clk);
      reset = 1'b0;

      // Directed walk through the main commands.
      run(5'b00010, 8'h34, 8'h12, -1, 5'b0);
      run(5'b00100, 8'h00, 8'h00, -1, 5'b0);
      pc = 16'h0100;
      run(5'b01000, 8'hA5, 8'h00, -1, 5'b0);
      pc = 16'h0100;
      run(5'b10000, 8'h5A, 8'h00, -1, 5'b0);
      run(5'b01001, 8'h99, 8'h88, 2, 5'b00010);

      // Commands while running are ignored.
      bus.pause = 1'b0;
      issue(5'b00010, -1, 5'b0);
      chk("ignored_when_running", busy_cycles, 0);
      bus.pause = 1'b1;

      // A CPU that never reads must time out.
      mute = 1'b1; drive_cpu();
      bus.sw_lo = 8'h11; bus.sw_hi = 8'h22;
      issue(5'b00010, -1, 5'b0);
      chk("timeout_busy_cycles", busy_cycles, 255);
      chk("timeout_err", s_err, 1);
      chk("timeout_no_reads", seen.size(), 0);
      chk("timeout_jam_en", s_jen, 0);
      mute = 1'b0; drive_cpu();

      // Randomized command mix.
      for (int k = 0; k < 14; k++) begin
         if ($urandom_range(0, 3) == 0) m = 5'($urandom_range(1, 31));
         else                           m = 5'(1 << $urandom_range(0, 4));
         if ($urandom_range(0, 2) == 0) pc = 16'($urandom);
         run(m, 8'($urandom), 8'($urandom), -1, 5'b0);
      end

      // Dropping pause mid-JAM abandons the command.
      bus.sw_lo = 8'h44; bus.sw_hi = 8'h33;
      set_cmds(5'b00010);
      step(); step(); step();
      chk("abort_in_jam", s_jen, 1);
      bus.pause = 1'b0;
      step();
      chk("abort_step_ce", s_ce, 0);
      step();
      chk("abort_busy", s_busy, 0);
      chk("abort_jam_en", s_jen, 0);
      chk("abort_err", s_err, 0);
      bus.pause = 1'b1; ph = 1; drive_cpu();

      // Async reset while the write strobe is up.
      bus.sw_lo = 8'h77;
      set_cmds(5'b01000);
      step();
      #1;
      chk("write_before_reset", bus.dep_we, 1);
      #1 reset = 1'b1;
      #1;
      chk("reset_kills_write", bus.dep_we, 0);
      chk("reset_kills_busy", bus.busy, 0);
      @(negedge clk);
      reset = 1'b0;
      run(5'b00010, 8'h78, 8'h56, -1, 5'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
